// File: rtl/lc3b_fetch_queue.sv
// Instruction fetch queue between IF and ID: circular buffer of {pc, ir} pairs
// with head-opcode predecode, whole-queue flush on redirect and optional empty bypass.

package lc3b_fetch_queue_pkg;
   typedef enum logic [3:0] {
      op_br   = 4'h0,
      op_add  = 4'h1,
      op_ldb  = 4'h2,
      op_stb  = 4'h3,
      op_jsr  = 4'h4,
      op_and  = 4'h5,
      op_ldr  = 4'h6,
      op_str  = 4'h7,
      op_rti  = 4'h8,
      op_not  = 4'h9,
      op_ldi  = 4'ha,
      op_sti  = 4'hb,
      op_jmp  = 4'hc,
      op_shf  = 4'hd,
      op_lea  = 4'he,
      op_trap = 4'hf
   } lc3b_opcode;
endpackage

module lc3b_fetch_queue
   import lc3b_fetch_queue_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int BYPASS = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [WIDTH-1:0]         enq_pc,
   input  logic [WIDTH-1:0]         enq_ir,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [WIDTH-1:0]         deq_pc,
   output logic [WIDTH-1:0]         deq_ir,
   output lc3b_opcode               deq_opcode,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam bit BYP = (BYPASS != 0);

   logic [WIDTH-1:0] mem_pc [DEPTH];
   logic [WIDTH-1:0] mem_ir [DEPTH];

   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;

   logic empty;
   logic full;
   logic enq_fire;
   logic deq_fire;
   logic pass_fire;
   logic wr_en;
   logic rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // enq_ready depends only on registered state and flush, never on deq_ready
   assign enq_ready = !full && !flush;
   assign deq_valid = !empty || (BYP && enq_valid && !flush);

   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready && !flush;

   // An empty-queue bypass hands the entry straight to decode; storage is untouched
   assign pass_fire = BYP && empty && enq_fire && deq_fire;
   assign wr_en     = enq_fire && !pass_fire;
   assign rd_en     = deq_fire && !pass_fire;

   always_comb begin
      deq_pc = '0;
      deq_ir = '0;
      if (!empty) begin
         deq_pc = mem_pc[head_q];
         deq_ir = mem_ir[head_q];
      end else if (BYP) begin
         deq_pc = enq_pc;
         deq_ir = enq_ir;
      end
   end

   assign deq_opcode = lc3b_opcode'(deq_ir[WIDTH-1 -: 4]);
   assign count      = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) tail_q <= tail_q + AW'(1);
         if (rd_en) head_q <= head_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[tail_q] <= enq_pc;
         mem_ir[tail_q] <= enq_ir;
      end
   end

endmodule
